// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer melody player.
//   - tone codes and note frequencies
//   - half_period(): clk cycles per square-wave half period for a tone/octave
//   - player FSM state encoding
package buzzer_pkg;

  localparam int TONE_W = 4;
  localparam int OCT_W  = 2;

  localparam logic [TONE_W-1:0] TONE_REST   = 4'd0;
  localparam logic [TONE_W-1:0] TONE_DO     = 4'd1;
  localparam logic [TONE_W-1:0] TONE_RE     = 4'd2;
  localparam logic [TONE_W-1:0] TONE_MI     = 4'd3;
  localparam logic [TONE_W-1:0] TONE_PA     = 4'd4;
  localparam logic [TONE_W-1:0] TONE_SOL    = 4'd5;
  localparam logic [TONE_W-1:0] TONE_RA     = 4'd6;
  localparam logic [TONE_W-1:0] TONE_SI     = 4'd7;
  localparam logic [TONE_W-1:0] TONE_HI_DO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Codes 0 and 9..15 are silent.
  function automatic logic is_rest(input logic [TONE_W-1:0] tone);
    return (tone == TONE_REST) || (tone > TONE_HI_DO);
  endfunction

  // Each branch divides by a literal so the whole function folds to a
  // constant table once host_hz is a parameter.
  function automatic int unsigned half_period(input int unsigned host_hz,
                                              input logic [TONE_W-1:0] tone,
                                              input logic [OCT_W-1:0] octave);
    int unsigned base;
    case (tone)
      TONE_DO:    base = host_hz / (2 * 523);
      TONE_RE:    base = host_hz / (2 * 587);
      TONE_MI:    base = host_hz / (2 * 659);
      TONE_PA:    base = host_hz / (2 * 698);
      TONE_SOL:   base = host_hz / (2 * 784);
      TONE_RA:    base = host_hz / (2 * 880);
      TONE_SI:    base = host_hz / (2 * 988);
      TONE_HI_DO: base = host_hz / (2 * 1047);
      default:    base = 0;
    endcase
    case (octave)
      2'd1:    return base >> 1;
      2'd2:    return base >> 2;
      2'd3:    return base << 1;
      default: return base;
    endcase
  endfunction

endpackage

// File: rtl/buzzer_melody_player_if.sv
// Note push channel between host logic and the melody player.
//   s_valid  : host has a note to push
//   s_ready  : player can accept a note this cycle
//   s_tone   : tone code (0 rest, 1..8 Do..Hi_Do, 9..15 rest)
//   s_octave : 0 base, 1 x2, 2 x4, 3 /2
//   s_dur    : note length in ticks
interface buzzer_melody_player_if
  import buzzer_pkg::*;
#(
  parameter int DUR_W = 12
);
  logic              s_valid;
  logic              s_ready;
  logic [TONE_W-1:0] s_tone;
  logic [OCT_W-1:0]  s_octave;
  logic [DUR_W-1:0]  s_dur;

  modport master (output s_valid, s_tone, s_octave, s_dur, input s_ready);
  modport slave  (input s_valid, s_tone, s_octave, s_dur, output s_ready);
endinterface

// File: rtl/buzzer_note_fifo.sv
// Synchronous show-ahead FIFO holding queued notes.
//   clk, rst : clock, synchronous active-high reset
//   i_clear  : empties the FIFO (same effect as reset on the pointers)
//   i_push   : write i_data (caller guarantees !o_full)
//   i_pop    : advance read pointer (caller guarantees !o_empty)
//   o_data   : entry at the head, valid while !o_empty
//   o_level  : number of queued entries
//   o_full, o_empty : status
module buzzer_note_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
endmodule

// File: rtl/buzzer_melody_player.sv
// Queued melody player driving the board buzzer.
//   clk, rst    : clock, synchronous active-high reset
//   enable      : 1 run, 0 pause (state and counters frozen, buzzer silent)
//   flush       : 1-cycle pulse, aborts the current note and empties the queue
//   s           : note push channel (slave side)
//   fifo_level  : number of queued notes
//   busy        : player active or notes queued
//   note_done   : 1-cycle pulse when a note's play phase ends
//   buzzer_out  : square-wave output
module buzzer_melody_player
  import buzzer_pkg::*;
#(
  parameter int unsigned HOST_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DUR_W      = 12,
  parameter int unsigned GAP_TICKS  = 10,
  parameter int          CNT_W      = 27
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          flush,
  buzzer_melody_player_if.slave         s,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          note_done,
  output logic                          buzzer_out
);
  localparam int unsigned TICK_DIV = HOST_HZ / TICK_HZ;
  localparam int          NOTE_W   = TONE_W + OCT_W + DUR_W;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] GAP_LOAD  = DUR_W'(GAP_TICKS);

  state_t            r_state, w_state_nxt;
  logic              w_full, w_empty, w_push, w_pop;
  logic [NOTE_W-1:0] w_head;
  logic [TONE_W-1:0] r_tone;
  logic [OCT_W-1:0]  r_oct;
  logic [DUR_W-1:0]  r_dur;
  logic [DUR_W-1:0]  r_remain;
  logic [CNT_W-1:0]  r_half, w_half;
  logic [CNT_W-1:0]  r_hz_cnt, r_tick_cnt;
  logic              r_out, r_note_done;
  logic              w_tick_wrap, w_last_tick, w_done_nxt, w_rest;

  assign s.s_ready = !w_full && !flush;
  assign w_push    = s.s_valid && s.s_ready;
  assign w_pop     = (r_state == ST_IDLE) && enable && !flush && !w_empty;

  buzzer_note_fifo #(.W(NOTE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({s.s_tone, s.s_octave, s.s_dur}),
    .o_data  (w_head),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_half      = CNT_W'(half_period(HOST_HZ, r_tone, r_oct));
  assign w_rest      = is_rest(r_tone);
  assign w_tick_wrap = (r_tick_cnt == TICK_LAST);
  // Remaining count is shared by PLAY (note ticks) and GAP (gap ticks).
  assign w_last_tick = w_tick_wrap && (r_remain == DUR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_empty) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (r_dur == '0) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (w_last_tick) begin
          w_state_nxt = (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_GAP:  if (w_last_tick) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!enable) begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
    end
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = 1'b0;
    end
  end

  // Note is captured from the FIFO head on the same edge it is popped.
  always_ff @(posedge clk) begin
    if (w_pop) {r_tone, r_oct, r_dur} <= w_head;
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD && enable && !flush) r_half <= w_half;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hz_cnt    <= '0;
      r_tick_cnt  <= '0;
      r_remain    <= '0;
      r_out       <= 1'b0;
      r_note_done <= 1'b0;
    end else begin
      r_note_done <= w_done_nxt;
      if (flush) begin
        r_hz_cnt   <= '0;
        r_tick_cnt <= '0;
        r_remain   <= '0;
        r_out      <= 1'b0;
      end else if (!enable) begin
        // Counters hold; phase restarts low when play resumes.
        r_out <= 1'b0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            r_hz_cnt   <= '0;
            r_tick_cnt <= '0;
            r_remain   <= r_dur;
            r_out      <= 1'b0;
          end
          ST_PLAY, ST_GAP: begin
            if (w_tick_wrap) begin
              r_tick_cnt <= '0;
              r_remain   <= r_remain - 1'b1;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            if (r_state == ST_PLAY && !w_rest) begin
              if (r_hz_cnt == r_half - CNT_W'(1)) begin
                r_hz_cnt <= '0;
                r_out    <= ~r_out;
              end else begin
                r_hz_cnt <= r_hz_cnt + 1'b1;
              end
            end
            if (w_last_tick) begin
              r_tick_cnt <= '0;
              r_hz_cnt   <= '0;
              r_remain   <= GAP_LOAD;
              r_out      <= 1'b0;
            end
          end
          default: r_out <= 1'b0;
        endcase
      end
    end
  end

  assign note_done  = r_note_done;
  assign buzzer_out = r_out && enable;
  assign busy       = (r_state != ST_IDLE) || (fifo_level != '0);
endmodule
